// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes diff = a - b - bin one full-subtractor stage per clock, LSB first,
// and reports the borrow-out, a zero flag and a signed-overflow flag.
// An operation takes WIDTH RUN cycles followed by a single DONE cycle.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    // Counter must be able to hold WIDTH itself, so it never wraps in RUN.
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;     // minuend, shifted right one bit per RUN cycle
    logic [WIDTH-1:0] sh_b;     // subtrahend, shifted right one bit per RUN cycle
    logic [WIDTH-1:0] diff_q;   // result, filled from the MSB end
    logic             br;       // borrow entering the current stage
    logic [CW-1:0]    cnt;      // number of stages already evaluated

    // Current full-subtractor stage.
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;

    assign x         = sh_a[0];
    assign y         = sh_b[0];
    assign d         = x ^ y ^ br;
    assign br_next   = (~x & y) | (~(x ^ y) & br);
    // After WIDTH right-shifts the first bit inserted at the MSB lands at bit 0.
    assign diff_next = {d, diff_q[WIDTH-1:1]};

    assign diff = diff_q;

    // Sequencer, datapath registers and registered flags in one process.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would chain within a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            diff_q <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bout   <= 1'b0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    br     <= br_next;
                    diff_q <= diff_next;
                    cnt    <= cnt + ONE;
                    if (cnt == LAST) begin
                        // br here is the borrow entering the MSB stage.
                        bout  <= br_next;
                        ovf   <= br ^ br_next;
                        zero  <= (diff_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor
// against an arithmetic reference model (WIDTH=8 and an exhaustive WIDTH=4 sweep).

module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, zero8, ovf8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, zero4, ovf4;
    logic [3:0] diff4;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wd(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    // Returns {ovf, zero, bout, diff[63:0]} for a w-bit subtraction.
    function automatic logic [66:0] sub_model(input int w, input logic [63:0] x,
                                              input logic [63:0] y, input logic bi);
        longint unsigned m, dv;
        longint sx, sy, sr, lo, hi;
        logic bo, z, ov;
        m  = (64'd1 << w) - 64'd1;
        dv = (x - y - 64'(bi)) & m;
        bo = (x < (y + 64'(bi)));
        sx = x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
        sy = y[w-1] ? (longint'(y) - (longint'(1) << w)) : longint'(y);
        sr = sx - sy - longint'(bi);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        ov = (sr < lo) || (sr > hi);
        z  = (dv == 0);
        return {ov, z, bo, dv};
    endfunction

    // k: 0 idle, 1..W busy, W+1 done (cycles since acceptance).
    int          k[2]    = '{0, 0};
    logic [63:0] ca[2]   = '{64'd0, 64'd0};
    logic [63:0] cb[2]   = '{64'd0, 64'd0};
    logic        cbin[2] = '{1'b0, 1'b0};
    logic [63:0] ed[2]   = '{64'd0, 64'd0};
    logic        ebo[2]  = '{1'b0, 1'b0};
    logic        ez[2]   = '{1'b1, 1'b1};
    logic        eo[2]   = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin : model
        logic [66:0] r;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                k[u]   <= 0;
                ed[u]  <= '0;
                ebo[u] <= 1'b0;
                ez[u]  <= 1'b1;
                eo[u]  <= 1'b0;
            end else if (k[u] == 0) begin
                if ((u == 0) ? start8 : start4) begin
                    k[u]    <= 1;
                    ca[u]   <= (u == 0) ? 64'(a8) : 64'(a4);
                    cb[u]   <= (u == 0) ? 64'(b8) : 64'(b4);
                    cbin[u] <= (u == 0) ? bin8 : bin4;
                end
            end else if (k[u] == wd(u)) begin
                r      = sub_model(wd(u), ca[u], cb[u], cbin[u]);
                k[u]   <= k[u] + 1;
                ed[u]  <= r[63:0];
                ebo[u] <= r[64];
                ez[u]  <= r[65];
                eo[u]  <= r[66];
            end else if (k[u] > wd(u)) begin
                k[u] <= 0;
            end else begin
                k[u] <= k[u] + 1;
            end
        end
    end

    task automatic cmp(input int u, input logic bsy, input logic dn, input logic [63:0] df,
                       input logic bo, input logic z, input logic ov);
        string p;
        p = (u == 0) ? "u8" : "u4";
        check({p, "_busy"}, 64'(bsy), 64'(k[u] >= 1 && k[u] <= wd(u)));
        check({p, "_done"}, 64'(dn), 64'(k[u] == wd(u) + 1));
        if (k[u] == 0 || k[u] == wd(u) + 1) begin
            check({p, "_diff"}, df, ed[u]);
            check({p, "_bout"}, 64'(bo), 64'(ebo[u]));
            check({p, "_zero"}, 64'(z), 64'(ez[u]));
            check({p, "_ovf"}, 64'(ov), 64'(eo[u]));
        end
    endtask

    always @(negedge clk) begin
        cmp(0, busy8, done8, 64'(diff8), bout8, zero8, ovf8);
        cmp(1, busy4, done4, 64'(diff4), bout4, zero4, ovf4);
    end

    // ---------------- directed helpers ----------------
    // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle.
    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input logic [7:0] x_diff, input logic x_bout, input logic x_zero,
                          input logic x_ovf, input string tag, input bit glitch);
        int n;
        start8 = 1'b1; a8 = ia; b8 = ib; bin8 = ibin;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        n = 1;
        while (!done8 && n < 20) begin
            if (glitch && n == 2) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h11; bin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd9);
        check({tag, "_diff"}, 64'(diff8), 64'(x_diff));
        check({tag, "_bout"}, 64'(bout8), 64'(x_bout));
        check({tag, "_zero"}, 64'(zero8), 64'(x_zero));
        check({tag, "_ovf"}, 64'(ovf8), 64'(x_ovf));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ndone;
        int dt[$];
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_diff", 64'(diff8), 64'd0);
        check("rst_zero", 64'(zero8), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First start accepted on the first edge after release.
        do_op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "r032", 1'b0);
        do_op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "r033", 1'b0);
        do_op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, "r034", 1'b0);
        do_op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "r035a", 1'b0);
        do_op8(8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "r035b", 1'b0);

        // Start pulsed during RUN is ignored; exactly one done pulse.
        do_op8(8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0, 1'b0, "r036", 1'b1);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("r036_extra_done", 64'(ndone), 64'd0);

        // Reset in the middle of RUN.
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("r037_busy", 64'(busy8), 64'd0);
        check("r037_done", 64'(done8), 64'd0);
        check("r037_diff", 64'(diff8), 64'd0);
        check("r037_bout", 64'(bout8), 64'd0);
        check("r037_zero", 64'(zero8), 64'd1);
        check("r037_ovf", 64'(ovf8), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, "r037_after", 1'b0);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        start8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(negedge clk);
            if (done8) dt.push_back(c);
        end
        start8 = 1'b0;
        check("r026_count", 64'(dt.size() >= 3), 64'd1);
        if (dt.size() >= 3) begin
            check("r026_gap1", 64'(dt[1] - dt[0]), 64'd10);
            check("r026_gap2", 64'(dt[2] - dt[1]), 64'd10);
        end
        repeat (12) @(negedge clk);

        // Random traffic, start arriving in any state.
        for (int c = 0; c < 1000; c++) begin
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive WIDTH=4 sweep with start held (one op per 6 cycles).
        start4 = 1'b1;
        for (int c = 0; c < 512; c++) begin
            a4 = 4'(c); b4 = 4'(c >> 4); bin4 = 1'(c >> 8);
            repeat (6) @(negedge clk);
        end
        start4 = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; the legal range is 2..64.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  is an asynchronous, active-high reset.
REQ-004 start  input  1  is a request to begin a subtraction; it is sampled only in IDLE.
REQ-005 a  input  WIDTH  is the minuend, captured at start acceptance.
REQ-006 b  input  WIDTH  is the subtrahend, captured at start acceptance.
REQ-007 bin  input  1  is the borrow-in to the LSB stage, captured at start acceptance.
REQ-008 busy  output  1  is high from the cycle after acceptance until done is asserted.
REQ-009 done  output  1  is a one-cycle pulse marking that the results are valid.
REQ-010 diff  output  WIDTH  is the result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  is the borrow-out of the MSB stage.
REQ-012 zero  output  1  is high when diff == 0.
REQ-013 ovf  output  1  is the two's-complement overflow flag: borrow into the MSB stage XOR bout.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL:
- load a and b into shift registers;
- load the borrow register from bin;
- clear the bit counter;
- go to RUN.
REQ-016 In RUN, one full-subtractor stage SHALL be evaluated per cycle, LSB first, on shifted bits x (from a), y (from b) and borrow br:
- d = x^y^br;
- br_next = (~x&y) | (~(x^y)&br).
REQ-017 Each d SHALL be shifted into the diff register from the MSB end, so that diff is bit-aligned after WIDTH shifts.
REQ-018 The br value entering the final (MSB) stage SHALL be held for the ovf computation.
REQ-019 After exactly WIDTH RUN cycles, the FSM SHALL go to DONE.
REQ-020 In DONE, the block SHALL drive:
- done=1 and busy=0;
- diff, bout, zero and ovf all valid.
REQ-021 The FSM SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-022 Latency: if start is accepted at edge N, busy SHALL be high for cycles N+1..N+WIDTH and done SHALL be high only in cycle N+WIDTH+1.
REQ-023 diff, bout, zero and ovf SHALL hold their last valid values through IDLE until the next acceptance.
REQ-024 diff, bout, zero and ovf MAY change during RUN and are not guaranteed to be valid there.
REQ-025 start SHALL be ignored in RUN and DONE; an accepted operation is never aborted or restarted by start.
REQ-026 start held high continuously SHALL give back-to-back operations, one every WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE).
REQ-027 Changes on a, b and bin after acceptance SHALL have no effect on the operation in progress.
REQ-028 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during RUN.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- busy=0, done=0;
- diff=0, bout=0, zero=1, ovf=0;
- counter and shift registers to 0.
REQ-030 rst asserted during RUN or DONE SHALL abort the operation, with no done pulse.
REQ-031 The first start SHALL be accepted at the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, bin=0 -> done at cycle N+9; diff=0x02, bout=0, zero=0, ovf=0.
REQ-033 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0, ovf=0.
REQ-034 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-035 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0; then a=0x2A, b=0x2A, bin=0 -> diff=0x00, zero=1.
REQ-036 Pulse start again at cycle N+3 with new operands -> the new operands are ignored, the first result is unchanged, and exactly one done pulse occurs.
REQ-037 Assert rst at cycle N+4 -> outputs take their reset values immediately, no done pulse, and a start after release completes normally.
REQ-038 An exhaustive sweep over all a, b and bin (WIDTH=4) SHALL match a reference model for diff, bout and ovf.
